mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/mem_stage_if.sv | 42 ++++
 rtl/mem_stage_dmem.sv | 27 ++
 rtl/mem_stage.sv | 107 ++++++++++
 tb/tb_mem_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, default sizes
// and the MEM/WB register layout.
package mem_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int DEFAULT_DEPTH    = 64;
   localparam int DEFAULT_LOAD_LAT = 2;
   localparam int DATA_W           = 32;
   localparam int REG_W            = 5;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_to_reg;
      logic              misaligned;
      logic [DATA_W-1:0] read_data;
      logic [DATA_W-1:0] alu_result;
      logic [REG_W-1:0]  rd;
   } wb_t;

   // A memory access whose byte address is not word aligned.
   function automatic logic is_misaligned(input logic [1:0] lsb, input logic rd, input logic wr);
      return (lsb != 2'b00) && (rd || wr);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM inputs and MEM->WB / fetch-side outputs of the MEM stage.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] pcout;
   logic              zero;
   logic              branch;
   logic              mem_read;
   logic              mem_write;
   logic              reg_write;
   logic              mem_to_reg;
   logic [REG_W-1:0]  rd;

   logic              stall;
   logic              pc_src;
   logic [DATA_W-1:0] branch_target;
   logic              wb_valid;
   logic              wb_reg_write;
   logic              wb_mem_to_reg;
   logic              wb_misaligned;
   logic [DATA_W-1:0] wb_read_data;
   logic [DATA_W-1:0] wb_alu_result;
   logic [REG_W-1:0]  wb_rd;

   modport master (
      output in_valid, address, write_data, pcout, zero, branch,
             mem_read, mem_write, reg_write, mem_to_reg, rd,
      input  stall, pc_src, branch_target, wb_valid, wb_reg_write,
             wb_mem_to_reg, wb_misaligned, wb_read_data, wb_alu_result, wb_rd
   );

   modport slave (
      input  in_valid, address, write_data, pcout, zero, branch,
             mem_read, mem_write, reg_write, mem_to_reg, rd,
      output stall, pc_src, branch_target, wb_valid, wb_reg_write,
             wb_mem_to_reg, wb_misaligned, wb_read_data, wb_alu_result, wb_rd
   );

endinterface

// File: rtl/mem_stage_dmem.sv
// Data memory: DEPTH x 32 words, synchronous write, combinational read.
module mem_stage_dmem
   import mem_stage_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // No reset: contents survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access with a multi-cycle load FSM that
// stalls upstream, branch resolution, and the MEM/WB pipeline register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int LOAD_LAT = DEFAULT_LOAD_LAT
) (
   input logic        clk,
   input logic        reset,
   mem_stage_if.slave bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LOAD_LAT + 1);

   state_t            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   wb_t               wb_reg;
   wb_t               pend_reg;
   logic [AW-1:0]     pend_idx_reg;

   logic              accept;
   logic              misaligned;
   logic              store_en;
   logic [AW-1:0]     idx;
   logic [DATA_W-1:0] rdata;
   wb_t               capture;
   wb_t               load_result;

   assign accept     = bus.in_valid && (state_reg == IDLE);
   assign misaligned = is_misaligned(bus.address[1:0], bus.mem_read, bus.mem_write);
   // A simultaneous read+write is a load, so the write side is dropped.
   assign store_en   = accept && bus.mem_write && !bus.mem_read && !misaligned;
   assign idx        = bus.address[AW+1:2];

   mem_stage_dmem #(.DEPTH(DEPTH), .AW(AW)) dmem (
      .clk   (clk),
      .we    (store_en),
      .waddr (idx),
      .wdata (bus.write_data),
      .raddr (pend_idx_reg),
      .rdata (rdata)
   );

   always_comb begin
      capture            = '0;
      capture.valid      = 1'b1;
      capture.reg_write  = bus.reg_write;
      capture.mem_to_reg = bus.mem_to_reg;
      capture.misaligned = misaligned;
      capture.alu_result = bus.address;
      capture.rd         = bus.rd;
      load_result           = pend_reg;
      load_result.read_data = pend_reg.misaligned ? '0 : rdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         wb_reg       <= '0;
         pend_reg     <= '0;
         pend_idx_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept && bus.mem_read) begin
                  state_reg    <= WAIT;
                  cnt_reg      <= CNT_W'(LOAD_LAT - 1);
                  pend_reg     <= capture;
                  pend_idx_reg <= idx;
                  wb_reg.valid <= 1'b0;
               end else if (accept) begin
                  wb_reg <= capture;
               end else begin
                  wb_reg.valid <= 1'b0;
               end
            end
            WAIT: begin
               // The cycle whose decrement reaches zero also retires the load.
               if (cnt_reg <= CNT_W'(1)) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
                  wb_reg    <= load_result;
               end else begin
                  cnt_reg      <= cnt_reg - CNT_W'(1);
                  wb_reg.valid <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.stall         = (state_reg == WAIT);
   assign bus.pc_src        = bus.in_valid && bus.branch && bus.zero && (state_reg == IDLE);
   assign bus.branch_target = bus.pcout;
   assign bus.wb_valid      = wb_reg.valid;
   assign bus.wb_reg_write  = wb_reg.reg_write;
   assign bus.wb_mem_to_reg = wb_reg.mem_to_reg;
   assign bus.wb_misaligned = wb_reg.misaligned;
   assign bus.wb_read_data  = wb_reg.read_data;
   assign bus.wb_alu_result = wb_reg.alu_result;
   assign bus.wb_rd         = wb_reg.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Table-driven bench for mem_stage with a scoreboard on the MEM/WB register.
module tb_mem_stage;

   logic clk = 1'b0;
   logic reset;

   mem_stage_if bus();

   mem_stage #(.DEPTH(64), .LOAD_LAT(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        reg_write;
      logic        mem_to_reg;
      logic        misaligned;
      logic [31:0] read_data;
      logic [31:0] alu_result;
      logic [4:0]  rd;
   } exp_t;

   typedef struct {
      logic [31:0] address;
      logic [31:0] write_data;
      logic [31:0] pcout;
      logic        zero;
      logic        branch;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        mem_to_reg;
      logic [4:0]  rd;
      int          exp_stall;
      logic        exp_pc_src;
      logic [31:0] exp_rdata;
      logic        exp_mis;
   } vec_t;

   localparam int NVEC = 15;

   exp_t sb_q[$];
   vec_t vecs[NVEC];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [72:0] wb_all();
      return {bus.wb_valid, bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_misaligned,
              bus.wb_read_data, bus.wb_alu_result, bus.wb_rd};
   endfunction

   task automatic sb_check();
      exp_t act;
      exp_t exp;
      if (reset !== 1'b1 || bus.wb_valid !== 1'b1) return;
      act = {bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_misaligned,
             bus.wb_read_data, bus.wb_alu_result, bus.wb_rd};
      check("wb_valid_expected", (sb_q.size() > 0) ? 1 : 0, 1);
      check("wb_during_stall", bus.stall, 0);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check("wb_fields", act, exp);
         $display("TXN rd=%0d alu=%h data=%h mis=%0b", bus.wb_rd, bus.wb_alu_result,
                  bus.wb_read_data, bus.wb_misaligned);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      sb_check();
   endtask

   task automatic drive(input vec_t v);
      bus.address    = v.address;
      bus.write_data = v.write_data;
      bus.pcout      = v.pcout;
      bus.zero       = v.zero;
      bus.branch     = v.branch;
      bus.mem_read   = v.mem_read;
      bus.mem_write  = v.mem_write;
      bus.reg_write  = v.reg_write;
      bus.mem_to_reg = v.mem_to_reg;
      bus.rd         = v.rd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vec_t v;

      // address, wdata, pcout, zero, branch, mrd, mwr, rw, m2r, rd, stall, pc_src, rdata, mis
      vecs[0]  = '{32'h4,   32'h1111_1111, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  0, 1'b0, 32'h0,         1'b0};
      vecs[1]  = '{32'h8,   32'hDEAD_BEEF, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  0, 1'b0, 32'h0,         1'b0};
      vecs[2]  = '{32'h8,   32'h0,         32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  1, 1'b0, 32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{32'h6,   32'hBAD0_BAD0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  0, 1'b0, 32'h0,         1'b1};
      vecs[4]  = '{32'h4,   32'h0,         32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4,  1, 1'b0, 32'h1111_1111, 1'b0};
      vecs[5]  = '{32'h108, 32'h0,         32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1, 1'b0, 32'hDEAD_BEEF, 1'b0};
      vecs[6]  = '{32'h0,   32'h0,         32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  0, 1'b1, 32'h0,         1'b0};
      vecs[7]  = '{32'h0,   32'h0,         32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  0, 1'b0, 32'h0,         1'b0};
      vecs[8]  = '{32'h5,   32'h0,         32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7,  0, 1'b0, 32'h0,         1'b0};
      vecs[9]  = '{32'hA,   32'h0,         32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  1, 1'b0, 32'h0,         1'b1};
      vecs[10] = '{32'hC,   32'h1234_5678, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  0, 1'b0, 32'h0,         1'b0};
      vecs[11] = '{32'hC,   32'hCAFE_F00D, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 1, 1'b0, 32'h1234_5678, 1'b0};
      vecs[12] = '{32'hC,   32'h0,         32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 1, 1'b0, 32'h1234_5678, 1'b0};
      vecs[13] = '{32'h10,  32'hA5A5_A5A5, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  0, 1'b0, 32'h0,         1'b0};
      vecs[14] = '{32'h10,  32'h0,         32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 1, 1'b0, 32'hA5A5_A5A5, 1'b0};

      // Reset held for three edges with idle inputs.
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      drive('{32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 0, 1'b0, 32'h0, 1'b0});
      repeat (3) tick();
      check("reset_wb", wb_all(), 0);
      check("reset_stall", bus.stall, 0);
      check("reset_pc_src", bus.pc_src, 0);
      reset = 1'b1;
      tick();
      check("post_reset_wb", wb_all(), 0);
      check("post_reset_stall", bus.stall, 0);

      // Table: one op per entry, inputs held through any stall.
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i]);
         bus.in_valid = 1'b1;
         #1;
         check("pc_src", bus.pc_src, vecs[i].exp_pc_src);
         check("branch_target", bus.branch_target, vecs[i].pcout);
         sb_q.push_back('{vecs[i].reg_write, vecs[i].mem_to_reg, vecs[i].exp_mis,
                          vecs[i].exp_rdata, vecs[i].address, vecs[i].rd});
         tick();
         n = 0;
         while (bus.stall === 1'b1 && n < 8) begin
            n++;
            tick();
         end
         bus.in_valid = 1'b0;
         check("stall_cycles", n, vecs[i].exp_stall);
         check("sb_drained", sb_q.size(), 0);
      end

      // Idle cycle: wb_valid drops, other fields hold the last load.
      tick();
      check("idle_wb_valid", bus.wb_valid, 0);
      check("idle_wb_rd", bus.wb_rd, 5'd12);
      check("idle_wb_read_data", bus.wb_read_data, 32'hA5A5_A5A5);
      check("idle_wb_alu_result", bus.wb_alu_result, 32'h10);

      // Reset during WAIT aborts the load.
      v = vecs[2];
      drive(v);
      bus.in_valid = 1'b1;
      tick();
      check("abort_stall_before", bus.stall, 1);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      check("abort_stall_after", bus.stall, 0);
      check("abort_wb", wb_all(), 0);
      reset = 1'b1;
      repeat (3) begin
         tick();
         check("abort_no_wb_valid", bus.wb_valid, 0);
      end

      // Stage accepts again after the abort.
      v = vecs[8];
      drive(v);
      bus.in_valid = 1'b1;
      sb_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 32'h5, 5'd7});
      tick();
      bus.in_valid = 1'b0;
      check("alu_after_abort_stall", bus.stall, 0);
      check("alu_after_abort_wb_valid", bus.wb_valid, 1);
      check("alu_after_abort_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
